// File: rtl/chart_sel_pkg.sv
// Shared state encoding, counter width and auto-repeat timing for the chart selector.
package chart_sel_pkg;

  localparam int unsigned CNT_W = 28;

  typedef enum logic [1:0] {
    ST_SELECT  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PLAYING = 2'd2,
    ST_RESULTS = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] AR_FIRST_LAST = CNT_W'(25000000 - 1);
  localparam logic [CNT_W-1:0] AR_NEXT_LAST  = CNT_W'(5000000 - 1);

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, counting debouncer, registered one-cycle press pulse.
// Synchroniser flops are not reset so a key held across reset is seen released before it can fire.
module key_debounce
  import chart_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_i,
  output logic press_o
`ifdef CHART_AUTOREPEAT_EN
  ,
  output logic level_o
`endif
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rdy_q, press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    sync1_q <= key_i;
    sync2_q <= sync1_q;
  end

  // Any cycle where the synchronised level agrees with the accepted one restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) level_d = sync2_q;
      else                  cnt_d   = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_q | ~sync2_q;
      press_q <= level_d & ~level_q & rdy_q;
    end
  end

  assign press_o = press_q;
`ifdef CHART_AUTOREPEAT_EN
  assign level_o = level_q;
`endif

endmodule

// File: rtl/chart_select_ctrl.sv
// Chart select / countdown / play / results controller; all outputs registered, one cycle after cause.
// Optional CHART_AUTOREPEAT_EN adds hold-to-repeat for next/prev while in SELECT.
module chart_select_ctrl
  import chart_sel_pkg::*;
#(
  parameter int unsigned NUM_CHARTS       = 3,
  parameter int unsigned DEBOUNCE_CYCLES  = 250000,
  parameter int unsigned COUNTDOWN_CYCLES = 150000000,
  parameter int unsigned BLINK_CYCLES     = 12500000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_next,
  input  logic       key_prev,
  input  logic       key_confirm,
  input  logic       song_done,
  output logic [3:0] chart_digit,
  output logic [1:0] state_code,
  output logic       start_pulse,
  output logic       game_active,
  output logic       label_blink
);

  localparam logic [3:0]       NC      = 4'(NUM_CHARTS);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNTDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BL_LAST = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic nxt_press, prv_press, cnf_press;
  logic nxt_ev, prv_ev, cnf_ev;

`ifdef CHART_AUTOREPEAT_EN
  logic nxt_lvl, prv_lvl, cnf_lvl;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .resetn(resetn), .key_i(key_next), .press_o(nxt_press), .level_o(nxt_lvl));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .resetn(resetn), .key_i(key_prev), .press_o(prv_press), .level_o(prv_lvl));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cnf (
    .clk(clk), .resetn(resetn), .key_i(key_confirm), .press_o(cnf_press), .level_o(cnf_lvl));

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_run_q, rep_run_d, rep_fire;

  // Only a single held direction repeats; both held counts as no repeat.
  always_comb begin
    rep_fire  = 1'b0;
    rep_cnt_d = '0;
    rep_run_d = 1'b0;
    if (state_code == ST_SELECT && (nxt_lvl ^ prv_lvl)) begin
      rep_run_d = rep_run_q;
      if (rep_cnt_q == (rep_run_q ? AR_NEXT_LAST : AR_FIRST_LAST)) begin
        rep_fire  = 1'b1;
        rep_run_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rep_cnt_q <= '0;
      rep_run_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_run_q <= rep_run_d;
    end
  end

  assign nxt_ev = nxt_press | (rep_fire & nxt_lvl);
  assign prv_ev = prv_press | (rep_fire & prv_lvl);
  assign cnf_ev = cnf_press;
`else
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .resetn(resetn), .key_i(key_next), .press_o(nxt_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .resetn(resetn), .key_i(key_prev), .press_o(prv_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cnf (
    .clk(clk), .resetn(resetn), .key_i(key_confirm), .press_o(cnf_press));

  assign nxt_ev = nxt_press;
  assign prv_ev = prv_press;
  assign cnf_ev = cnf_press;
`endif

  state_e           state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, bcnt_q, bcnt_d;
  logic             start_q, start_d, act_q, act_d, blink_q, blink_d;

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      ST_SELECT: begin
        if (cnf_ev) begin
          state_d = ST_ARMED;
          cnt_d   = CD_LAST;
        end else if (nxt_ev && !prv_ev) begin
          digit_d = (digit_q == NC) ? 4'd1 : digit_q + 4'd1;
        end else if (prv_ev && !nxt_ev) begin
          digit_d = (digit_q == 4'd1) ? NC : digit_q - 4'd1;
        end
      end
      ST_ARMED: begin
        if (cnt_q == '0) begin
          state_d = ST_PLAYING;
          start_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_PLAYING: if (song_done) state_d = ST_RESULTS;
      ST_RESULTS: if (cnf_ev) state_d = ST_SELECT;
      default:    state_d = ST_SELECT;
    endcase

    // Blink restarts low on every entry to ARMED and is forced high elsewhere.
    blink_d = 1'b1;
    bcnt_d  = '0;
    if (state_d == ST_ARMED) begin
      if (state_q != ST_ARMED) begin
        blink_d = 1'b0;
      end else if (bcnt_q == BL_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + ONE;
      end
    end
    act_d = (state_d == ST_PLAYING);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_SELECT;
      digit_q <= 4'd1;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      start_q <= 1'b0;
      act_q   <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      start_q <= start_d;
      act_q   <= act_d;
      blink_q <= blink_d;
    end
  end

  assign chart_digit = digit_q;
  assign state_code  = state_q;
  assign start_pulse = start_q;
  assign game_active = act_q;
  assign label_blink = blink_q;

endmodule

// File: tb/tb_chart_select_ctrl.sv
// Bench for chart_select_ctrl: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a cycle-indexed behavioural model.
module tb_chart_select_ctrl;

  localparam int NUM = 3;
  localparam int DB  = 4;
  localparam int CD  = 10;
  localparam int BL  = 2;

  logic       clk, resetn, key_next, key_prev, key_confirm, song_done;
  logic [3:0] chart_digit;
  logic [1:0] state_code;
  logic       start_pulse, game_active, label_blink;

  int total = 0;
  int bad   = 0;

  chart_select_ctrl #(
    .NUM_CHARTS(NUM), .DEBOUNCE_CYCLES(DB), .COUNTDOWN_CYCLES(CD), .BLINK_CYCLES(BL)
  ) dut (
    .clk(clk), .resetn(resetn), .key_next(key_next), .key_prev(key_prev),
    .key_confirm(key_confirm), .song_done(song_done), .chart_digit(chart_digit),
    .state_code(state_code), .start_pulse(start_pulse), .game_active(game_active),
    .label_blink(label_blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keys seen through a two-edge delay, accepted after DB consecutive differing
  // samples; FSM timing expressed as edge-count distances from the ARMED entry edge.
  int  m_state = 0, m_digit = 1, m_start = 0, m_act = 0, m_blink = 1;
  int  cyc = 0, k_arm = 0;
  bit  r1[3], r2[3], lvl[3], rdy[3], prs[3];
  int  run[3];

  task automatic model_step();
    bit raw[3];
    bit ev[3];
    raw[0] = key_next; raw[1] = key_prev; raw[2] = key_confirm;
    cyc++;
    if (!resetn) begin
      m_state = 0; m_digit = 1; m_start = 0; m_act = 0; m_blink = 1;
      for (int k = 0; k < 3; k++) begin
        lvl[k] = 0; run[k] = 0; rdy[k] = 0; prs[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) ev[k] = prs[k];
      m_start = 0;
      case (m_state)
        0: begin
          if (ev[2]) begin m_state = 1; k_arm = cyc; end
          else if (ev[0] && !ev[1]) m_digit = m_digit % NUM + 1;
          else if (ev[1] && !ev[0]) m_digit = (m_digit + NUM - 2) % NUM + 1;
        end
        1: if (cyc - k_arm == CD) begin m_state = 2; m_start = 1; end
        2: if (song_done) m_state = 3;
        default: if (ev[2]) m_state = 0;
      endcase
      m_act   = (m_state == 2);
      m_blink = (m_state == 1) ? ((cyc - k_arm) / BL) % 2 : 1;
      for (int k = 0; k < 3; k++) begin
        prs[k] = 0;
        if (r2[k] != lvl[k]) begin
          run[k]++;
          if (run[k] == DB) begin
            lvl[k] = r2[k];
            run[k] = 0;
            prs[k] = lvl[k] && rdy[k];
          end
        end else begin
          run[k] = 0;
        end
        rdy[k] = rdy[k] | !r2[k];
      end
    end
    for (int k = 0; k < 3; k++) begin
      r2[k] = r1[k];
      r1[k] = raw[k];
    end
  endtask

  initial begin : compare
    @(posedge clk);
    forever begin
      model_step();
      #1;
      chk("state_code", int'(state_code), m_state);
      chk("chart_digit", int'(chart_digit), m_digit);
      chk("start_pulse", int'(start_pulse), m_start);
      chk("game_active", int'(game_active), m_act);
      chk("label_blink", int'(label_blink), m_blink);
      @(posedge clk);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input bit n, input bit p, input bit c, input int hold);
    key_next = n; key_prev = p; key_confirm = c;
    repeat (hold) tick();
    key_next = 0; key_prev = 0; key_confirm = 0;
    repeat (12) tick();
  endtask

  task automatic wait_state(input int s);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (int'(state_code) == s) hit = 1;
    end
    if (!hit) chk("wait_state", int'(state_code), s);
  endtask

  int pat[10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
  int starts;

  initial begin : stim
    resetn = 0; key_next = 0; key_prev = 0; key_confirm = 0; song_done = 0;
    repeat (5) tick();
    resetn = 1;
    tick();
    chk("rst_state", int'(state_code), 0);
    chk("rst_digit", int'(chart_digit), 1);
    chk("rst_blink", int'(label_blink), 1);
    chk("rst_active", int'(game_active), 0);

    press(1, 0, 0, 6); chk("next1", int'(chart_digit), 2);
    press(1, 0, 0, 6); chk("next2", int'(chart_digit), 3);
    press(1, 0, 0, 6); chk("next3_wrap", int'(chart_digit), 1);
    press(0, 1, 0, 6); chk("prev_wrap", int'(chart_digit), 3);
    press(1, 1, 0, 6); chk("both", int'(chart_digit), 3);

    repeat (3) begin
      key_next = 1; repeat (2) tick();
      key_next = 0; repeat (3) tick();
    end
    repeat (10) tick();
    chk("glitch", int'(chart_digit), 3);
    press(1, 0, 0, 5); chk("hold5", int'(chart_digit), 1);
    press(1, 0, 0, 6); chk("to2", int'(chart_digit), 2);

    key_confirm = 1;
    wait_state(1);
    key_confirm = 0;
    for (int i = 0; i < 10; i++) begin
      chk("armed_blink", int'(label_blink), pat[i]);
      chk("armed_nostart", int'(start_pulse), 0);
      tick();
    end
    chk("start_at10", int'(start_pulse), 1);
    chk("playing", int'(state_code), 2);
    chk("active", int'(game_active), 1);

    press(1, 0, 0, 6); press(0, 1, 0, 6); press(0, 0, 1, 6);
    chk("play_digit", int'(chart_digit), 2);
    chk("play_state", int'(state_code), 2);

    song_done = 1; tick(); song_done = 0;
    chk("results", int'(state_code), 3);
    press(0, 0, 1, 6);
    chk("back_select", int'(state_code), 0);
    chk("kept_digit", int'(chart_digit), 2);
    song_done = 1; tick(); song_done = 0; repeat (3) tick();
    chk("done_in_select", int'(state_code), 0);

    key_confirm = 1;
    wait_state(1);
    key_confirm = 0;
    repeat (5) tick();
    starts = 0;
    resetn = 0;
    repeat (3) begin tick(); starts += int'(start_pulse); end
    resetn = 1;
    tick();
    chk("abort_state", int'(state_code), 0);
    chk("abort_digit", int'(chart_digit), 1);
    repeat (30) begin tick(); starts += int'(start_pulse); end
    chk("abort_nostart", starts, 0);

    key_next = 1; resetn = 0;
    repeat (4) tick();
    resetn = 1;
    repeat (15) tick();
    chk("held_reset", int'(chart_digit), 1);
    key_next = 0;
    repeat (12) tick();
    chk("held_release", int'(chart_digit), 1);
    press(1, 0, 0, 6);
    chk("after_held", int'(chart_digit), 2);

    for (int it = 0; it < 300; it++) begin
      key_next    = ($urandom_range(0, 2) == 0);
      key_prev    = ($urandom_range(0, 2) == 0);
      key_confirm = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 8)) begin
        song_done = ($urandom_range(0, 15) == 0);
        tick();
      end
      key_next = 0; key_prev = 0; key_confirm = 0; song_done = 0;
      repeat ($urandom_range(0, 8)) tick();
      if ($urandom_range(0, 50) == 0) begin
        resetn = 0;
        repeat ($urandom_range(1, 3)) tick();
        resetn = 1;
      end
    end
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chart_select_ctrl.md
CHART_SELECT_CTRL -- requirements
Module: chart_select_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHARTS, default 3, number of selectable charts (1..9).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, stable-level cycles needed to accept a key change.
REQ-003 SHALL have parameter COUNTDOWN_CYCLES, default 150000000, cycles from confirm to game start.
REQ-004 SHALL have parameter BLINK_CYCLES, default 12500000, half-period of label_blink during countdown.
REQ-005 SHALL have ports: clk  input  1  system clock; resetn  input  1  synchronous active-low reset.
REQ-006 SHALL have ports: key_next, key_prev, key_confirm  input  1 each  raw asynchronous active-high buttons.
REQ-007 SHALL have port: song_done  input  1  single-cycle pulse from the playback engine.
REQ-008 SHALL have ports: chart_digit  output  4  selected chart number, feeds label overlay; state_code  output  2  current state.
REQ-009 SHALL have ports: start_pulse  output  1  one-cycle game start; game_active  output  1  high in PLAYING; label_blink  output  1  overlay enable toggle.

Function
REQ-010 SHALL pass each key through a 2-flop synchroniser, then a debouncer; a press event is the debounced 0->1 edge, exactly one cycle wide.
REQ-011 SHALL accept a new debounced level only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-012 SHALL implement states SELECT(0), ARMED(1), PLAYING(2), RESULTS(3), driven on state_code.
REQ-013 In SELECT, next event SHALL increment chart_digit, wrapping NUM_CHARTS->1; prev SHALL decrement, wrapping 1->NUM_CHARTS.
REQ-014 Simultaneous next and prev events SHALL leave chart_digit unchanged.
REQ-015 Confirm event in SELECT SHALL move to ARMED and load countdown with COUNTDOWN_CYCLES-1; confirm takes priority over next/prev in the same cycle (digit unchanged).
REQ-016 In ARMED the countdown SHALL decrement each cycle; on reaching 0 the FSM SHALL enter PLAYING and assert start_pulse for exactly that transition cycle.
REQ-017 In ARMED label_blink SHALL toggle every BLINK_CYCLES, starting low on entry; in all other states label_blink SHALL be 1.
REQ-018 In ARMED and PLAYING, next/prev/confirm events SHALL be ignored; chart_digit SHALL be frozen.
REQ-019 game_active SHALL be 1 in PLAYING only; song_done in PLAYING SHALL move to RESULTS next cycle; song_done in other states SHALL be ignored.
REQ-020 Confirm event in RESULTS SHALL return to SELECT, retaining chart_digit.
REQ-021 All outputs SHALL be registered; state change visible one cycle after the causing event.
REQ-022 Counters SHALL be 28 bits wide; parameters exceeding 2^28-1 are illegal.

Reset
REQ-023 On resetn=0 at a clk edge: state SELECT, chart_digit=1, start_pulse=0, game_active=0, label_blink=1, countdown=0, debounced levels=0, debounce counters=0.
REQ-024 Reset mid-ARMED or mid-PLAYING SHALL abort with no start_pulse emitted.
REQ-025 A key held through reset release SHALL NOT generate a press event until released and pressed again.

Configuration
REQ-026 Macro CHART_AUTOREPEAT_EN defined: holding next/prev in SELECT SHALL repeat the event after 25000000 cycles, then every 5000000 cycles while held.
REQ-027 Macro CHART_AUTOREPEAT_EN undefined: one event per press only; no repeat counter logic present.

Structure
REQ-028 Package chart_sel_pkg SHALL hold the state encoding constants and the 28-bit counter width constant.
REQ-029 Sub-module key_debounce (synchroniser, debouncer, edge pulse) SHALL be instantiated once per key.

Verification (DEBOUNCE_CYCLES=4, COUNTDOWN_CYCLES=10, BLINK_CYCLES=2, NUM_CHARTS=3)
REQ-030 Reset, press next 3 times -> chart_digit 1->2->3->1.
REQ-031 From 1 press prev once -> 3; next and prev in the same cycle -> stays 3.
REQ-032 Next with 2-cycle glitches only -> no event; held 5 cycles -> exactly one increment.
REQ-033 Confirm at digit 2 -> state 1, label_blink toggles every 2 cycles, start_pulse high exactly 10 cycles after the state change, state 2, game_active=1, keys ignored.
REQ-034 song_done in PLAYING -> state 3; confirm -> state 0 with digit 2; song_done in SELECT -> no effect.
REQ-035 resetn low 5 cycles into ARMED -> state 0, digit 1, no start_pulse ever asserted.
